// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: latency-corrected golden-nonce FIFO with a host read handshake.
// `define NONCE_DEDUP_EN to drop a nonce equal to the last accepted one.
module golden_nonce_queue #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] NONCE_OFFSET = 32'd0,
    parameter logic [31:0] EMPTY_VALUE  = 32'hFFFFFFFF
) (
    input  logic                     hash_clk,
    input  logic                     rst,
    input  logic                     rx_new_nonce,
    input  logic [31:0]              rx_golden_nonce,
    input  logic                     flush,
    input  logic                     rd_req,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic [15:0]              overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0] adj;
    logic dup, do_pop, do_push, drop;
`ifdef NONCE_DEDUP_EN
    logic        last_valid;
    logic [31:0] last_nonce;
`endif
    always_comb begin
        adj = rx_golden_nonce - NONCE_OFFSET;
`ifdef NONCE_DEDUP_EN
        dup = last_valid && adj == last_nonce;
`else
        dup = 1'b0;
`endif
        empty = count == '0;
        full = count == FULL_CNT;
        do_pop = rd_req && !empty && !flush;
        // a same-cycle pop frees the slot, so a full queue still accepts the write
        do_push = rx_new_nonce && !flush && !dup && (!full || rd_req);
        drop = rx_new_nonce && !flush && !dup && full && !rd_req;
    end
    assign rd_valid = state == RESP;
    always_ff @(posedge hash_clk)
        if (do_push) mem[wr_ptr] <= adj;
    always_ff @(posedge hash_clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_data <= EMPTY_VALUE;
            overflow_cnt <= '0;
        end else begin
            state <= rd_req ? RESP : IDLE;
            if (rd_req) rd_data <= do_pop ? mem[rd_ptr] : EMPTY_VALUE;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
            if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        end
    end
`ifdef NONCE_DEDUP_EN
    always_ff @(posedge hash_clk) begin
        if (rst || flush) last_valid <= 1'b0;
        else if (do_push) begin
            last_valid <= 1'b1;
            last_nonce <= adj;
        end
    end
`endif
endmodule
